// File: rtl/divide_result_unpack_if.sv
// Bundle of the divider-result input side and the downstream fixed-point output side.
// The master drives the divider result and the downstream ready; the slave is the unpacker.
interface divide_result_unpack_if #(
  parameter int DSIZE = 24,
  parameter int FSIZE = 8
);
  logic [2*DSIZE-1:0] Q;
  logic [5:0]         EXP;
  logic               VALID;
  logic               HOLD;
  logic [DSIZE-1:0]   INT_OUT;
  logic [FSIZE-1:0]   FRAC_OUT;
  logic               SAT;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               OVERFLOW;
  logic               CLR_OVF;

  modport master (
    output Q, EXP, VALID, OUT_READY, CLR_OVF,
    input  HOLD, INT_OUT, FRAC_OUT, SAT, OUT_VALID, OVERFLOW
  );

  modport slave (
    input  Q, EXP, VALID, OUT_READY, CLR_OVF,
    output HOLD, INT_OUT, FRAC_OUT, SAT, OUT_VALID, OVERFLOW
  );
endinterface

// File: rtl/divide_result_unpack.sv
// Captures divider Q/EXP results into a small FIFO (the divider cannot be stalled),
// converts Q / 2^EXP into a rounded, saturated fixed-point value and hands it
// downstream over valid/ready. HOLD throttles the operand source before overflow.
module divide_result_unpack #(
  parameter int DSIZE = 24,
  parameter int FSIZE = 8,
  parameter int AW    = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  divide_result_unpack_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int EW    = 2*DSIZE + 6;           // stored entry: {Q, EXP}
  localparam int RW    = 2*DSIZE + FSIZE + 1;   // rounded intermediate width
  localparam int CW    = RW + 64;               // headroom so a 2^(EXP-1) addend never truncates
  localparam int OW    = DSIZE + FSIZE;         // representable result width
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] HOLD_C  = DEPTH_C - 1'b1;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             out_valid_reg, sat_reg, overflow_reg;
  logic [DSIZE-1:0] int_reg;
  logic [FSIZE-1:0] frac_reg;

  logic             full, empty, push, pop, drop;
  logic [EW-1:0]    head;
  logic [2*DSIZE-1:0] head_q;
  logic [5:0]       head_exp;
  logic [CW-1:0]    scaled, r_wide;
  logic             sat_next;
  logic [DSIZE-1:0] int_next;
  logic [FSIZE-1:0] frac_next;

  // Push/pop decisions; a pop frees a slot so a push into a full FIFO still succeeds.
  always_comb begin
    full  = (count_reg == DEPTH_C);
    empty = (count_reg == '0);
    pop   = !empty && (!out_valid_reg || bus.OUT_READY);
    push  = bus.VALID && (!full || pop);
    drop  = bus.VALID && full && !pop;
  end

  // FIFO storage; only the pointers need reset, stale entries are never read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= {bus.Q, bus.EXP};
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Convert the FIFO head: round-half-up shift of Q<<FSIZE by EXP, then saturate.
  always_comb begin
    head     = mem[rd_ptr_reg];
    head_q   = head[EW-1:6];
    head_exp = head[5:0];
    scaled   = CW'(head_q) << FSIZE;
    if (head_exp == 6'd0) r_wide = scaled;
    else r_wide = (scaled + (CW'(1) << (head_exp - 6'd1))) >> head_exp;
    sat_next  = |r_wide[CW-1:OW];
    int_next  = sat_next ? '1 : r_wide[OW-1:FSIZE];
    frac_next = sat_next ? '1 : r_wide[FSIZE-1:0];
  end

  // Output register: load on pop, drain when accepted with nothing behind it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      sat_reg       <= 1'b0;
      int_reg       <= '0;
      frac_reg      <= '0;
    end else if (pop) begin
      out_valid_reg <= 1'b1;
      sat_reg       <= sat_next;
      int_reg       <= int_next;
      frac_reg      <= frac_next;
    end else if (bus.OUT_READY) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)             overflow_reg <= 1'b0;
    else if (drop)        overflow_reg <= 1'b1;
    else if (bus.CLR_OVF) overflow_reg <= 1'b0;
  end

  assign bus.HOLD      = (count_reg >= HOLD_C);
  assign bus.OUT_VALID = out_valid_reg;
  assign bus.SAT       = sat_reg;
  assign bus.INT_OUT   = int_reg;
  assign bus.FRAC_OUT  = frac_reg;
  assign bus.OVERFLOW  = overflow_reg;
endmodule

// File: tb/tb_divide_result_unpack.sv
// Directed bench for divide_result_unpack: rounding, saturation, backpressure,
// overflow, full-FIFO push/pop and asynchronous reset mid-stream.
module tb_divide_result_unpack;
  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   errors = 0;
  int   checks = 0;

  divide_result_unpack_if #(.DSIZE(24), .FSIZE(8)) bus ();

  divide_result_unpack #(.DSIZE(24), .FSIZE(8), .AW(2)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one result for a single edge.
  task automatic pulse(input logic [47:0] q, input logic [5:0] e);
    bus.Q = q; bus.EXP = e; bus.VALID = 1'b1;
    step();
    bus.VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.Q = '0; bus.EXP = '0; bus.VALID = 1'b0; bus.OUT_READY = 1'b0; bus.CLR_OVF = 1'b0;
    step(); step();
    checks++;
    if ({bus.OUT_VALID, bus.SAT, bus.OVERFLOW, bus.HOLD, bus.INT_OUT, bus.FRAC_OUT} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", {bus.OUT_VALID, bus.SAT, bus.OVERFLOW, bus.HOLD, bus.INT_OUT, bus.FRAC_OUT});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_rounding();
    bus.OUT_READY = 1'b1;
    pulse(48'd600, 6'd4);
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL latency_early: OUT_VALID got %b required 0", bus.OUT_VALID);
    end
    step();
    $display("round_half: int=%0d frac=%h sat=%b", bus.INT_OUT, bus.FRAC_OUT, bus.SAT);
    checks++;
    if ({bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT} !== {1'b1, 1'b0, 24'd37, 8'h80}) begin
      errors++;
      $display("FAIL round_half: got v=%b s=%b int=%0d frac=%h required v=1 s=0 int=37 frac=80",
               bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT);
    end
    step();
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL drain: OUT_VALID got %b required 0", bus.OUT_VALID);
    end
  endtask

  task automatic test_small();
    pulse(48'd3, 6'd10);
    step();
    $display("small_q3_e10: int=%0d frac=%h sat=%b", bus.INT_OUT, bus.FRAC_OUT, bus.SAT);
    checks++;
    if ({bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT} !== {1'b1, 1'b0, 24'd0, 8'h01}) begin
      errors++;
      $display("FAIL small_q3_e10: got v=%b s=%b int=%0d frac=%h required v=1 s=0 int=0 frac=01",
               bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT);
    end
    pulse(48'd5, 6'd63);
    step();
    $display("small_q5_e63: int=%0d frac=%h sat=%b", bus.INT_OUT, bus.FRAC_OUT, bus.SAT);
    checks++;
    if ({bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT} !== {1'b1, 1'b0, 24'd0, 8'h00}) begin
      errors++;
      $display("FAIL small_q5_e63: got v=%b s=%b int=%0d frac=%h required v=1 s=0 int=0 frac=00",
               bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT);
    end
    step();
  endtask

  task automatic test_saturation();
    pulse(48'h1000000, 6'd0);
    step();
    $display("sat_2p24: int=%h frac=%h sat=%b", bus.INT_OUT, bus.FRAC_OUT, bus.SAT);
    checks++;
    if ({bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT} !== {1'b1, 1'b1, 24'hFFFFFF, 8'hFF}) begin
      errors++;
      $display("FAIL sat_2p24: got v=%b s=%b int=%h frac=%h required v=1 s=1 int=ffffff frac=ff",
               bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT);
    end
    pulse(48'hFFFFFF, 6'd0);
    step();
    $display("nosat_max: int=%h frac=%h sat=%b", bus.INT_OUT, bus.FRAC_OUT, bus.SAT);
    checks++;
    if ({bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT} !== {1'b1, 1'b0, 24'hFFFFFF, 8'h00}) begin
      errors++;
      $display("FAIL nosat_max: got v=%b s=%b int=%h frac=%h required v=1 s=0 int=ffffff frac=00",
               bus.OUT_VALID, bus.SAT, bus.INT_OUT, bus.FRAC_OUT);
    end
    step();
  endtask

  task automatic test_backpressure_overflow();
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.Q = 48'(100 + i); bus.EXP = 6'd0; bus.VALID = 1'b1;
      step();
      checks++;
      if (bus.HOLD !== (i >= 3)) begin
        errors++; $display("FAIL hold_push%0d: got %b required %b", i + 1, bus.HOLD, (i >= 3));
      end
      checks++;
      if (bus.OVERFLOW !== (i == 5)) begin
        errors++; $display("FAIL ovf_push%0d: got %b required %b", i + 1, bus.OVERFLOW, (i == 5));
      end
    end
    bus.VALID = 1'b0;
    step();
    checks++;
    if ({bus.OUT_VALID, bus.INT_OUT} !== {1'b1, 24'd100}) begin
      errors++; $display("FAIL held_output: got v=%b int=%0d required v=1 int=100", bus.OUT_VALID, bus.INT_OUT);
    end
    bus.OUT_READY = 1'b1;
    for (int j = 0; j < 5; j++) begin
      $display("bp_drain %0d: v=%b int=%0d", j, bus.OUT_VALID, bus.INT_OUT);
      checks++;
      if ({bus.OUT_VALID, bus.INT_OUT, bus.FRAC_OUT} !== {1'b1, 24'(100 + j), 8'h00}) begin
        errors++;
        $display("FAIL bp_order%0d: got v=%b int=%0d required v=1 int=%0d", j, bus.OUT_VALID, bus.INT_OUT, 100 + j);
      end
      step();
    end
    checks++;
    if ({bus.OUT_VALID, bus.HOLD, bus.OVERFLOW} !== 3'b001) begin
      errors++;
      $display("FAIL bp_after_drain: got v=%b hold=%b ovf=%b required v=0 hold=0 ovf=1", bus.OUT_VALID, bus.HOLD, bus.OVERFLOW);
    end
    bus.CLR_OVF = 1'b1;
    step();
    bus.CLR_OVF = 1'b0;
    checks++;
    if (bus.OVERFLOW !== 1'b0) begin
      errors++; $display("FAIL clr_ovf: got %b required 0", bus.OVERFLOW);
    end
  endtask

  task automatic test_full_push_pop();
    logic [23:0] want [5];
    want = '{24'd201, 24'd202, 24'd203, 24'd204, 24'd299};
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) pulse(48'(200 + i), 6'd0);
    checks++;
    if ({bus.OUT_VALID, bus.INT_OUT, bus.HOLD, bus.OVERFLOW} !== {1'b1, 24'd200, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_fill: got v=%b int=%0d hold=%b ovf=%b required v=1 int=200 hold=1 ovf=0",
               bus.OUT_VALID, bus.INT_OUT, bus.HOLD, bus.OVERFLOW);
    end
    bus.OUT_READY = 1'b1;
    pulse(48'd299, 6'd0);
    bus.OUT_READY = 1'b0;
    checks++;
    if ({bus.OVERFLOW, bus.HOLD} !== 2'b01) begin
      errors++; $display("FAIL full_pushpop_flags: got ovf=%b hold=%b required ovf=0 hold=1", bus.OVERFLOW, bus.HOLD);
    end
    bus.OUT_READY = 1'b1;
    for (int j = 0; j < 5; j++) begin
      $display("fp_drain %0d: v=%b int=%0d", j, bus.OUT_VALID, bus.INT_OUT);
      checks++;
      if ({bus.OUT_VALID, bus.INT_OUT} !== {1'b1, want[j]}) begin
        errors++;
        $display("FAIL fp_order%0d: got v=%b int=%0d required v=1 int=%0d", j, bus.OUT_VALID, bus.INT_OUT, want[j]);
      end
      step();
    end
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL fp_empty: OUT_VALID got %b required 0", bus.OUT_VALID);
    end
  endtask

  task automatic test_reset_midstream();
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) pulse(48'(400 + i), 6'd0);
    checks++;
    if ({bus.OUT_VALID, bus.HOLD, bus.INT_OUT} !== {1'b1, 1'b1, 24'd400}) begin
      errors++;
      $display("FAIL mid_setup: got v=%b hold=%b int=%0d required v=1 hold=1 int=400", bus.OUT_VALID, bus.HOLD, bus.INT_OUT);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.OUT_VALID, bus.HOLD, bus.SAT, bus.INT_OUT, bus.FRAC_OUT} !== 35'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got v=%b hold=%b int=%0d frac=%h required all 0",
               bus.OUT_VALID, bus.HOLD, bus.INT_OUT, bus.FRAC_OUT);
    end
    step();
    rst = 1'b1;
    bus.OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.OUT_VALID !== 1'b0) begin
        errors++; $display("FAIL mid_stale%0d: OUT_VALID got %b required 0 (int=%0d)", k, bus.OUT_VALID, bus.INT_OUT);
      end
    end
    pulse(48'd600, 6'd4);
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL mid_latency_early: OUT_VALID got %b required 0", bus.OUT_VALID);
    end
    step();
    $display("mid_after_reset: v=%b int=%0d frac=%h", bus.OUT_VALID, bus.INT_OUT, bus.FRAC_OUT);
    checks++;
    if ({bus.OUT_VALID, bus.INT_OUT, bus.FRAC_OUT} !== {1'b1, 24'd37, 8'h80}) begin
      errors++;
      $display("FAIL mid_after_reset: got v=%b int=%0d frac=%h required v=1 int=37 frac=80",
               bus.OUT_VALID, bus.INT_OUT, bus.FRAC_OUT);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_small();
    test_saturation();
    test_backpressure_overflow();
    test_full_push_pop();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
